// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with imem/dmem handshakes and a bus watchdog.
// Define MULTICYCLE_CTRL_PERF_EN to add the retired-instruction counter output.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       op,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             we,
  output logic             w_src,
  output logic             reg_wr,
  output logic [5:0]       alu_ctr,
  output logic             busy,
  output logic             err
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_t;

  typedef enum logic [1:0] {C_RTYPE, C_LOAD, C_STORE, C_IMM} cls_t;

  localparam bit             WD_EN   = (TIMEOUT_CYCLES > 0);
  localparam int             TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  WD_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state, state_nxt;
  cls_t          cls, cls_dec;
  logic [TW-1:0] wd_cnt;
  logic          wd_inc;
  logic          reg_dst_dec, alu_src_dec, w_src_dec;
  logic [5:0]    alu_ctr_dec;

  always_comb begin
    cls_dec     = C_RTYPE;
    reg_dst_dec = 1'b0;
    alu_src_dec = 1'b0;
    w_src_dec   = 1'b0;
    alu_ctr_dec = 6'd0;
    if (!op[5]) begin
      cls_dec     = C_RTYPE;
      reg_dst_dec = 1'b1;
      alu_src_dec = 1'b1;
      w_src_dec   = 1'b1;
      alu_ctr_dec = op;
    end else if (!op[4]) begin
      cls_dec = C_LOAD;
    end else if (!op[3]) begin
      cls_dec = C_STORE;
    end else begin
      cls_dec     = C_IMM;
      w_src_dec   = 1'b1;
      alu_ctr_dec = {3'b000, op[2:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      wd_cnt  <= '0;
      cls     <= C_RTYPE;
      reg_dst <= 1'b0;
      alu_src <= 1'b0;
      w_src   <= 1'b0;
      alu_ctr <= 6'd0;
    end else begin
      state <= state_nxt;
      // Every state change restarts the wait count, which covers entry to FETCH and MEM.
      if (state_nxt != state) wd_cnt <= '0;
      else if (wd_inc)        wd_cnt <= wd_cnt + 1'b1;
      if (state == S_DECODE) begin
        cls     <= cls_dec;
        reg_dst <= reg_dst_dec;
        alu_src <= alu_src_dec;
        w_src   <= w_src_dec;
        alu_ctr <= alu_ctr_dec;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wd_inc    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    we        = 1'b0;
    reg_wr    = 1'b0;
    busy      = (state != S_IDLE) && (state != S_ERR);
    err       = (state == S_ERR);
    case (state)
      S_IDLE: if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end else if (WD_EN) begin
          // An ack in the limit cycle takes the branch above, so it wins over the trap.
          if (wd_cnt == WD_LAST) state_nxt = S_ERR;
          else                   wd_inc    = 1'b1;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: state_nxt = (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        we       = (cls == C_STORE);
        if (dmem_ack) begin
          if (cls == C_STORE) begin
            pc_we     = 1'b1;
            state_nxt = run ? S_FETCH : S_IDLE;
          end else begin
            state_nxt = S_WB;
          end
        end else if (WD_EN) begin
          if (wd_cnt == WD_LAST) state_nxt = S_ERR;
          else                   wd_inc    = 1'b1;
        end
      end
      S_WB: begin
        reg_wr    = 1'b1;
        pc_we     = 1'b1;
        state_nxt = run ? S_FETCH : S_IDLE;
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        retired <= '0;
    else if (pc_we) retired <= retired + 1'b1;
  end
`endif

endmodule
